// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the UDP receive path: FSM states, error codes,
// header byte offsets and protocol constants.
package udp_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_HDR  = 3'd2,
      ST_PAY  = 3'd3,
      ST_TAIL = 3'd4,
      ST_DROP = 3'd5
   } state_t;

   localparam logic [2:0] ERR_OK     = 3'd0;
   localparam logic [2:0] ERR_FCS    = 3'd1;
   localparam logic [2:0] ERR_RXER   = 3'd2;
   localparam logic [2:0] ERR_PROTO  = 3'd3;
   localparam logic [2:0] ERR_ADDR   = 3'd4;
   localparam logic [2:0] ERR_IPCSUM = 3'd5;
   localparam logic [2:0] ERR_LEN    = 3'd6;

   // Offsets counted from the first byte after the SFD
   localparam logic [5:0] OFF_DST_MAC   = 6'd0;
   localparam logic [5:0] OFF_SRC_MAC   = 6'd6;
   localparam logic [5:0] OFF_ETYPE     = 6'd12;
   localparam logic [5:0] OFF_IP        = 6'd14;
   localparam logic [5:0] OFF_IP_PROTO  = 6'd23;
   localparam logic [5:0] OFF_IP_SRC    = 6'd26;
   localparam logic [5:0] OFF_IP_DST    = 6'd30;
   localparam logic [5:0] OFF_UDP_SPORT = 6'd34;
   localparam logic [5:0] OFF_UDP_DPORT = 6'd36;
   localparam logic [5:0] OFF_UDP_LEN   = 6'd38;
   localparam logic [5:0] OFF_HDR_LAST  = 6'd41;

   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_VER_IHL     = 8'h45;
   localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
   localparam logic [7:0]  PRE_BYTE       = 8'h55;
   localparam logic [7:0]  SFD_BYTE       = 8'hD5;
   localparam logic [31:0] CRC_POLY       = 32'hEDB88320;
   localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB20E3;

   function automatic logic in_field(input logic [5:0] cnt, input logic [5:0] off,
                                     input logic [5:0] len);
      return (cnt >= off) && (cnt < off + len);
   endfunction

endpackage

// File: rtl/udp_rx_packet_crc32.sv
// Byte-wide reflected CRC-32 (Ethernet FCS) with clear and enable; the register
// is not inverted, so a good frame including its FCS leaves the fixed residue.
module crc32_d8
   import udp_rx_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);

   logic [31:0] r_crc;
   logic [31:0] w_next;

   always_comb begin
      w_next = r_crc ^ {24'd0, i_data};
      for (int unsigned i = 0; i < 8; i++) begin
         w_next = w_next[0] ? ((w_next >> 1) ^ CRC_POLY) : (w_next >> 1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)     r_crc <= '1;
      else if (i_clr) r_crc <= '1;
      else if (i_en)  r_crc <= w_next;
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/udp_rx_packet.sv
// UDP receive path: parses preamble/Ethernet/IPv4/UDP, filters on MAC/IP/port and
// streams payload with metadata. Define UDP_RX_IPCSUM_EN to check the IPv4 checksum.
module udp_rx_packet
   import udp_rx_pkg::*;
#(
   parameter logic [47:0] LOCAL_MAC   = 48'h0023543c471b,
   parameter logic [31:0] LOCAL_IP    = 32'hc0a84d21,
   parameter logic [15:0] LOCAL_PORT  = 16'hc360,
   parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_rx_dv,
   input  logic        i_rx_er,
   input  logic [7:0]  i_rx_data,
   output logic        o_udp_valid,
   output logic [7:0]  o_udp_data,
   output logic        o_udp_sof,
   output logic        o_udp_eof,
   output logic [15:0] o_udp_len,
   output logic [47:0] o_src_mac,
   output logic [31:0] o_src_ip,
   output logic [15:0] o_src_port,
   output logic        o_pkt_done,
   output logic        o_pkt_ok,
   output logic [2:0]  o_err,
   output logic [2:0]  o_state
);

   state_t      r_state, w_next;
   logic [5:0]  r_hdr_cnt;
   logic        r_in_frame;
   logic [2:0]  r_err;
   logic [47:0] r_dst_mac, r_src_mac;
   logic [15:0] r_etype;
   logic [7:0]  r_ver_ihl, r_proto;
   logic [31:0] r_src_ip, r_dst_ip;
   logic [15:0] r_sport, r_dport, r_ulen;
   logic [15:0] r_pay_cnt;
   logic [31:0] w_crc;
   logic [15:0] w_pay_len;
   logic        w_sfd, w_done, w_hdr_last, w_fwd;
   logic [2:0]  w_hdr_err, w_final_err;

`ifdef UDP_RX_IPCSUM_EN
   logic [7:0]  r_csum_hi;
   logic [19:0] r_csum_acc;
   logic [16:0] w_fold1;
   logic [15:0] w_csum_fold;

   // High byte of each header word waits for its partner; one add per word
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_csum_hi  <= '0;
         r_csum_acc <= '0;
      end else if (w_sfd) begin
         r_csum_acc <= '0;
      end else if (r_state == ST_HDR && i_rx_dv && in_field(r_hdr_cnt, OFF_IP, 6'd20)) begin
         if (!r_hdr_cnt[0]) r_csum_hi  <= i_rx_data;
         else               r_csum_acc <= r_csum_acc + {4'd0, r_csum_hi, i_rx_data};
      end
   end

   assign w_fold1     = {1'b0, r_csum_acc[15:0]} + {13'd0, r_csum_acc[19:16]};
   assign w_csum_fold = w_fold1[15:0] + {15'd0, w_fold1[16]};
`endif

   crc32_d8 u_crc (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_sfd),
      .i_en   (r_in_frame && i_rx_dv),
      .i_data (i_rx_data),
      .o_crc  (w_crc)
   );

   assign w_pay_len = r_ulen - 16'd8;

   always_comb begin
      w_hdr_err = ERR_OK;
      if (r_etype != ETHERTYPE_IPV4 || r_ver_ihl != IP_VER_IHL || r_proto != IP_PROTO_UDP)
         w_hdr_err = ERR_PROTO;
      else if ((r_dst_mac != LOCAL_MAC && r_dst_mac != 48'hffffffffffff) ||
               r_dst_ip != LOCAL_IP || r_dport != LOCAL_PORT)
         w_hdr_err = ERR_ADDR;
`ifdef UDP_RX_IPCSUM_EN
      else if (w_csum_fold != 16'hFFFF)
         w_hdr_err = ERR_IPCSUM;
`endif
      else if (r_ulen < 16'd8 || w_pay_len > MAX_PAYLOAD)
         w_hdr_err = ERR_LEN;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_DROP;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_rx_dv) begin
               if (i_rx_data == PRE_BYTE)      w_next = ST_PRE;
               else if (i_rx_data == SFD_BYTE) w_next = ST_HDR;
               else                            w_next = ST_DROP;
            end
         end
         ST_PRE: begin
            if (!i_rx_dv)                   w_next = ST_IDLE;
            else if (i_rx_data == SFD_BYTE) w_next = ST_HDR;
            else if (i_rx_data != PRE_BYTE) w_next = ST_DROP;
         end
         ST_HDR: begin
            if (!i_rx_dv)                  w_next = ST_IDLE;
            else if (i_rx_er)              w_next = ST_DROP;
            else if (r_hdr_cnt == OFF_HDR_LAST) begin
               if (w_hdr_err != ERR_OK)    w_next = ST_DROP;
               else if (r_ulen == 16'd8)   w_next = ST_TAIL;
               else                        w_next = ST_PAY;
            end
         end
         ST_PAY: begin
            if (!i_rx_dv)                  w_next = ST_IDLE;
            else if (i_rx_er)              w_next = ST_DROP;
            else if (r_pay_cnt == 16'd1)   w_next = ST_TAIL;
         end
         ST_TAIL: begin
            if (!i_rx_dv)                  w_next = ST_IDLE;
            else if (i_rx_er)              w_next = ST_DROP;
         end
         default: begin
            if (!i_rx_dv)                  w_next = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      w_sfd      = (r_state == ST_IDLE || r_state == ST_PRE) && i_rx_dv && i_rx_data == SFD_BYTE;
      w_done     = r_in_frame && !i_rx_dv;
      w_hdr_last = r_state == ST_HDR && i_rx_dv && !i_rx_er && r_hdr_cnt == OFF_HDR_LAST;
      w_fwd      = r_state == ST_PAY && i_rx_dv && !i_rx_er;
      if (r_err != ERR_OK)                           w_final_err = r_err;
      else if (r_state == ST_HDR || r_state == ST_PAY) w_final_err = ERR_LEN;
      else if (w_crc != CRC_RESIDUE)                 w_final_err = ERR_FCS;
      else                                           w_final_err = ERR_OK;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_udp_valid <= 1'b0;
         o_udp_data  <= '0;
         o_udp_sof   <= 1'b0;
         o_udp_eof   <= 1'b0;
         o_udp_len   <= '0;
         o_src_mac   <= '0;
         o_src_ip    <= '0;
         o_src_port  <= '0;
         o_pkt_done  <= 1'b0;
         o_pkt_ok    <= 1'b0;
         o_err       <= '0;
         r_in_frame  <= 1'b0;
         r_err       <= ERR_OK;
         r_hdr_cnt   <= '0;
         r_pay_cnt   <= '0;
         r_dst_mac   <= '0;
         r_src_mac   <= '0;
         r_etype     <= '0;
         r_ver_ihl   <= '0;
         r_proto     <= '0;
         r_src_ip    <= '0;
         r_dst_ip    <= '0;
         r_sport     <= '0;
         r_dport     <= '0;
         r_ulen      <= '0;
      end else begin
         o_udp_valid <= w_fwd;
         o_udp_sof   <= w_fwd && (r_pay_cnt == o_udp_len);
         o_udp_eof   <= w_fwd && (r_pay_cnt == 16'd1);
         if (w_fwd) begin
            o_udp_data <= i_rx_data;
            r_pay_cnt  <= r_pay_cnt - 16'd1;
         end

         o_pkt_done <= w_done;
         if (w_done) begin
            o_err      <= w_final_err;
            o_pkt_ok   <= (w_final_err == ERR_OK);
            r_in_frame <= 1'b0;
         end

         // A PHY error overrides any header verdict already latched
         if (w_sfd) begin
            r_in_frame <= 1'b1;
            r_hdr_cnt  <= '0;
            r_err      <= ERR_OK;
         end else if (r_in_frame && i_rx_dv && i_rx_er) begin
            r_err <= ERR_RXER;
         end else if (w_hdr_last) begin
            r_err <= w_hdr_err;
         end

         if (r_state == ST_HDR && i_rx_dv) begin
            r_hdr_cnt <= r_hdr_cnt + 6'd1;
            if (in_field(r_hdr_cnt, OFF_DST_MAC, 6'd6))   r_dst_mac <= {r_dst_mac[39:0], i_rx_data};
            if (in_field(r_hdr_cnt, OFF_SRC_MAC, 6'd6))   r_src_mac <= {r_src_mac[39:0], i_rx_data};
            if (in_field(r_hdr_cnt, OFF_ETYPE, 6'd2))     r_etype   <= {r_etype[7:0], i_rx_data};
            if (r_hdr_cnt == OFF_IP)                      r_ver_ihl <= i_rx_data;
            if (r_hdr_cnt == OFF_IP_PROTO)                r_proto   <= i_rx_data;
            if (in_field(r_hdr_cnt, OFF_IP_SRC, 6'd4))    r_src_ip  <= {r_src_ip[23:0], i_rx_data};
            if (in_field(r_hdr_cnt, OFF_IP_DST, 6'd4))    r_dst_ip  <= {r_dst_ip[23:0], i_rx_data};
            if (in_field(r_hdr_cnt, OFF_UDP_SPORT, 6'd2)) r_sport   <= {r_sport[7:0], i_rx_data};
            if (in_field(r_hdr_cnt, OFF_UDP_DPORT, 6'd2)) r_dport   <= {r_dport[7:0], i_rx_data};
            if (in_field(r_hdr_cnt, OFF_UDP_LEN, 6'd2))   r_ulen    <= {r_ulen[7:0], i_rx_data};
         end

         if (w_hdr_last && w_hdr_err == ERR_OK) begin
            o_udp_len  <= w_pay_len;
            o_src_mac  <= r_src_mac;
            o_src_ip   <= r_src_ip;
            o_src_port <= r_sport;
            r_pay_cnt  <= w_pay_len;
         end
      end
   end

   assign o_state = r_state;

endmodule

// File: tb/tb_udp_rx_packet.sv
// Self-checking bench for udp_rx_packet: directed and random frames checked
// against a frame-level reference model of the receive verdict and payload.
module tb_udp_rx_packet;

   localparam logic [47:0] L_MAC   = 48'h0023543c471b;
   localparam logic [31:0] L_IP    = 32'hc0a84d21;
   localparam logic [15:0] L_PORT  = 16'hc360;
   localparam logic [47:0] S_MAC   = 48'hd8d38526c578;
   localparam logic [31:0] S_IP    = 32'hc0a84dd9;
   localparam logic [15:0] S_PORT  = 16'hc350;
   localparam logic [47:0] BCAST   = 48'hffffffffffff;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dv = 1'b0;
   logic        er = 1'b0;
   logic [7:0]  d = 8'h00;
   logic        o_udp_valid, o_udp_sof, o_udp_eof, o_pkt_done, o_pkt_ok;
   logic [7:0]  o_udp_data;
   logic [15:0] o_udp_len, o_src_port;
   logic [47:0] o_src_mac;
   logic [31:0] o_src_ip;
   logic [2:0]  o_err, o_state;

   always #5 clk = ~clk;

   udp_rx_packet dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_rx_dv     (dv),
      .i_rx_er     (er),
      .i_rx_data   (d),
      .o_udp_valid (o_udp_valid),
      .o_udp_data  (o_udp_data),
      .o_udp_sof   (o_udp_sof),
      .o_udp_eof   (o_udp_eof),
      .o_udp_len   (o_udp_len),
      .o_src_mac   (o_src_mac),
      .o_src_ip    (o_src_ip),
      .o_src_port  (o_src_port),
      .o_pkt_done  (o_pkt_done),
      .o_pkt_ok    (o_pkt_ok),
      .o_err       (o_err),
      .o_state     (o_state)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: records payload beats and end-of-frame reports
   logic [7:0]  beats[$];
   int          n_sof, sof_idx, n_eof, eof_idx, n_done;
   logic [2:0]  m_err;
   logic        m_ok;
   logic [15:0] m_len, m_sport;
   logic [47:0] m_smac;
   logic [31:0] m_sip;

   always @(negedge clk) begin
      if (o_udp_valid) begin
         if (o_udp_sof) begin n_sof++; sof_idx = beats.size(); end
         if (o_udp_eof) begin n_eof++; eof_idx = beats.size(); end
         beats.push_back(o_udp_data);
      end
      if (o_pkt_done) begin
         n_done++;
         m_err = o_err; m_ok = o_pkt_ok; m_len = o_udp_len;
         m_smac = o_src_mac; m_sip = o_src_ip; m_sport = o_src_port;
      end
   end

   task automatic clear_mon();
      beats.delete();
      n_sof = 0; sof_idx = -1; n_eof = 0; eof_idx = -1; n_done = 0;
   endtask

   logic [7:0]  fr[$];
   logic [7:0]  pay[$];
   logic [31:0] crc_tab[256];

   function automatic void init_tab();
      for (int i = 0; i < 256; i++) begin
         logic [31:0] c;
         c = 32'(i);
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         crc_tab[i] = c;
      end
   endfunction

   function automatic logic [31:0] fcs_of();
      logic [31:0] c = '1;
      foreach (fr[k]) c = crc_tab[c[7:0] ^ fr[k]] ^ (c >> 8);
      return ~c;
   endfunction

   function automatic logic [15:0] ip_csum(input logic [15:0] w[10]);
      int s = 0;
      for (int i = 0; i < 10; i++) s += int'(w[i]);
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      return ~s[15:0];
   endfunction

   task automatic build(input logic [47:0] dmac, input logic [31:0] dip, input logic [15:0] sport,
                        input logic [15:0] dport, input logic [15:0] ulen, input int plen,
                        input int cdelta, input bit bad_fcs, input bit seq);
      logic [15:0] w[10];
      logic [47:0] smac = S_MAC;
      logic [31:0] sip = S_IP;
      logic [31:0] f;
      logic [7:0]  b;
      fr.delete(); pay.delete();
      for (int i = 0; i < 6; i++) fr.push_back(dmac[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) fr.push_back(smac[47-8*i -: 8]);
      fr.push_back(8'h08); fr.push_back(8'h00);
      w = '{16'h4500, 16'd20 + ulen, 16'h0000, 16'h4000, 16'h4011, 16'h0000,
            sip[31:16], sip[15:0], dip[31:16], dip[15:0]};
      w[5] = ip_csum(w) + cdelta[15:0];
      for (int i = 0; i < 10; i++) begin fr.push_back(w[i][15:8]); fr.push_back(w[i][7:0]); end
      fr.push_back(sport[15:8]); fr.push_back(sport[7:0]);
      fr.push_back(dport[15:8]); fr.push_back(dport[7:0]);
      fr.push_back(ulen[15:8]);  fr.push_back(ulen[7:0]);
      fr.push_back(8'h00); fr.push_back(8'h00);
      for (int i = 0; i < plen; i++) begin
         b = seq ? i[7:0] : 8'($urandom);
         pay.push_back(b); fr.push_back(b);
      end
      while (fr.size() < 60) fr.push_back(8'h00);
      f = fcs_of();
      fr.push_back(f[7:0]); fr.push_back(f[15:8]); fr.push_back(f[23:16]); fr.push_back(f[31:24]);
      if (bad_fcs) fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h01;
   endtask

   // Sends preamble, SFD and post-SFD bytes; cut<0 sends all, rst_idx pulses reset with that byte
   task automatic send(input int cut, input int er_idx, input int rst_idx);
      int n = (cut < 0) ? fr.size() : cut;
      for (int i = 0; i < 8; i++) begin
         dv = 1'b1; d = (i == 7) ? 8'hD5 : 8'h55;
         @(posedge clk); #1;
      end
      for (int i = 0; i < n; i++) begin
         d = fr[i]; er = (i == er_idx); rst_n = (i != rst_idx);
         @(posedge clk); #1;
         if (i == rst_idx) begin
            rst_n = 1'b1;
            chk("rst.valid", o_udp_valid, 0);
            chk("rst.done", o_pkt_done, 0);
            chk("rst.len", o_udp_len, 0);
            chk("rst.src_ip", o_src_ip, 0);
            chk("rst.state", o_state, 5);
         end
      end
      dv = 1'b0; er = 1'b0; d = 8'h00;
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input string nm, input logic [47:0] dmac, input logic [31:0] dip,
                            input logic [15:0] sport, input logic [15:0] dport,
                            input logic [15:0] ulen, input int plen, input int cdelta,
                            input bit bad_fcs, input bit seq, input int cut, input int er_idx);
      bit reached, er_hit, addr_bad, csum_bad, len_bad, hdr_pass, eof_exp;
      int e, nb, mm;
      build(dmac, dip, sport, dport, ulen, plen, cdelta, bad_fcs, seq);
      clear_mon();
      send(cut, er_idx, -1);

      reached  = (cut < 0) || (cut >= 42);
      er_hit   = (er_idx >= 0) && (er_idx < 42) && (cut < 0 || er_idx < cut);
      addr_bad = reached && (!(dmac == L_MAC || dmac == BCAST) || dip != L_IP || dport != L_PORT);
`ifdef UDP_RX_IPCSUM_EN
      csum_bad = reached && (cdelta != 0);
`else
      csum_bad = 1'b0;
`endif
      len_bad  = reached && (ulen < 16'd8 || ulen > 16'd1480);
      hdr_pass = reached && !er_hit && !addr_bad && !csum_bad && !len_bad;
      if (er_hit)                                   e = 2;
      else if (addr_bad)                            e = 4;
      else if (csum_bad)                            e = 5;
      else if (len_bad)                             e = 6;
      else if (cut >= 0 && cut < 42 + plen)         e = 6;
      else if (bad_fcs || cut >= 0)                 e = 1;
      else                                          e = 0;
      nb = !hdr_pass ? 0 : (cut < 0 ? plen : ((cut - 42 < plen) ? cut - 42 : plen));
      eof_exp = hdr_pass && plen > 0 && nb == plen;

      chk({nm, ".done"}, n_done, 1);
      chk({nm, ".err"}, m_err, e);
      chk({nm, ".ok"}, m_ok, (e == 0));
      chk({nm, ".beats"}, beats.size(), nb);
      mm = 0;
      for (int i = 0; i < nb && i < beats.size(); i++) if (beats[i] !== pay[i]) mm++;
      chk({nm, ".payload"}, mm, 0);
      chk({nm, ".sof_cnt"}, n_sof, (nb > 0) ? 1 : 0);
      chk({nm, ".eof_cnt"}, n_eof, eof_exp ? 1 : 0);
      if (nb > 0) begin
         chk({nm, ".sof_pos"}, sof_idx, 0);
         if (eof_exp) chk({nm, ".eof_pos"}, eof_idx, nb - 1);
         chk({nm, ".udp_len"}, m_len, plen);
         chk({nm, ".src_ip"}, m_sip, S_IP);
         chk({nm, ".src_mac"}, m_smac, S_MAC);
         chk({nm, ".src_port"}, m_sport, sport);
      end
   endtask

   initial begin
      init_tab();
      clear_mon();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.valid", o_udp_valid, 0);
      chk("reset.done", o_pkt_done, 0);
      chk("reset.ok", o_pkt_ok, 0);
      chk("reset.err", o_err, 0);
      chk("reset.len", o_udp_len, 0);
      chk("reset.src_mac", o_src_mac, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle.state", o_state, 0);
      chk("idle.valid", o_udp_valid, 0);

      run_frame("std",      L_MAC, L_IP, S_PORT, L_PORT, 16'd26, 18, 0, 1'b0, 1'b1, -1, -1);
      run_frame("badfcs",   L_MAC, L_IP, S_PORT, L_PORT, 16'd26, 18, 0, 1'b1, 1'b1, -1, -1);
      run_frame("badport",  L_MAC, L_IP, S_PORT, 16'hc351, 16'd26, 18, 0, 1'b0, 1'b1, -1, -1);
      run_frame("badip",    L_MAC, 32'hc0a84d22, S_PORT, L_PORT, 16'd26, 18, 0, 1'b0, 1'b1, -1, -1);
      run_frame("badmac",   48'h0023543c471c, L_IP, S_PORT, L_PORT, 16'd26, 18, 0, 1'b0, 1'b1, -1, -1);
      run_frame("bcast",    BCAST, L_IP, S_PORT, L_PORT, 16'd26, 18, 0, 1'b0, 1'b1, -1, -1);
      run_frame("ipcsum",   L_MAC, L_IP, S_PORT, L_PORT, 16'd26, 18, 1, 1'b0, 1'b1, -1, -1);
      run_frame("ulen4",    L_MAC, L_IP, S_PORT, L_PORT, 16'd4, 0, 0, 1'b0, 1'b1, -1, -1);
      run_frame("ulen8",    L_MAC, L_IP, S_PORT, L_PORT, 16'd8, 0, 0, 1'b0, 1'b1, -1, -1);
      run_frame("toolong",  L_MAC, L_IP, S_PORT, L_PORT, 16'd1481, 0, 0, 1'b0, 1'b1, -1, -1);
      run_frame("maxpay",   L_MAC, L_IP, S_PORT, L_PORT, 16'd1480, 1472, 0, 1'b0, 1'b0, -1, -1);
      run_frame("trunc",    L_MAC, L_IP, S_PORT, L_PORT, 16'd26, 18, 0, 1'b0, 1'b1, 52, -1);
      run_frame("rxer",     L_MAC, L_IP, S_PORT, L_PORT, 16'd26, 18, 0, 1'b0, 1'b1, -1, 20);

      // Reset pulse with payload byte 5: five beats already out, no done for this frame
      build(L_MAC, L_IP, S_PORT, L_PORT, 16'd26, 18, 0, 1'b0, 1'b1);
      clear_mon();
      send(-1, -1, 47);
      chk("midrst.done", n_done, 0);
      chk("midrst.beats", beats.size(), 5);
      chk("midrst.state", o_state, 0);
      run_frame("after_rst", L_MAC, L_IP, S_PORT, L_PORT, 16'd26, 18, 0, 1'b0, 1'b1, -1, -1);

      for (int r = 0; r < 8; r++) begin
         int plen = $urandom_range(1, 64);
         logic [47:0] dm = ($urandom_range(0, 1) == 0) ? L_MAC : BCAST;
         logic [15:0] sp = 16'($urandom);
         bit bf = ($urandom_range(0, 3) == 0);
         int ct = ($urandom_range(0, 3) == 0) ? 42 + $urandom_range(0, plen - 1) : -1;
         run_frame($sformatf("rand%0d", r), dm, L_IP, sp, L_PORT, 16'(plen + 8), plen, 0, bf, 1'b0, ct, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
